ball_sprite_fetch: RTL and testbench
====================================

Name: ball_sprite_fetch

Overview:
Pipelined reader for the ball sprite ROM. It sits between the VGA pixel scan and the ROM. For each scanned pixel it decides whether the pixel lies inside the ball's bounding box, drives the ROM address, size and fire selects, and returns a registered palette index with an on/transparent flag to the colour mapper. Ball position, size and fire mode are latched once per frame so the sprite cannot tear mid-scan. The block also counts the opaque ball pixels drawn in each frame, for collision and debug use.

Parameters:
ADDR_W, 19, ROM address width (matches ROM read_address)
COORD_W, 10, DrawX/DrawY/ball coordinate width
CNT_W, 9, opaque-pixel counter width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank; latches ball state
ball_x  in  COORD_W  sprite box left column (live, from game control)
ball_y  in  COORD_W  sprite box top row (live)
ball_size_in  in  2  0: 8x8, 1: 12x12, 2/3: 16x16
is_fire_in  in  1  fire sprite, always 16x16, overrides size
pix_valid  in  1  DrawX/DrawY valid this cycle
DrawX  in  COORD_W  scan column
DrawY  in  COORD_W  scan row
rom_data  in  4  ROM palette index (combinational from rom_address)
rom_address  out  ADDR_W  ROM read address
rom_ball_size  out  2  latched size to ROM
rom_is_fire  out  1  latched fire flag to ROM
pix_out_valid  out  1  result valid, 2 cycles after pix_valid
ball_on  out  1  pixel inside box and rom_data != 0
ball_color_idx  out  4  rom_data if ball_on, else 0
last_frame_count  out  CNT_W  opaque pixels drawn in the previous frame

Behaviour:
- Reset, synchronous: all outputs 0. Shadow registers sx, sy, ssize, sfire are 0. Pipeline valids and the counter are cleared.
- Reset asserted mid-pipeline: in-flight pixels are discarded. No pix_out_valid is produced for them.
- Shadow latch:
  - frame_start high in cycle t loads sx/sy/ssize/sfire at edge t+1.
  - A pixel accepted in cycle t uses the pre-update shadow values.
  - rom_ball_size and rom_is_fire are driven from the shadow registers.
- Width W = 16 if sfire, else 8/12/16 for ssize 0/1/(2,3).
- Stage 1 (edge after pix_valid):
  - Compare in COORD_W+1 bits so the box never wraps: inbox = (DrawX >= sx) && (DrawX < sx+W) && (DrawY >= sy) && (DrawY < sy+W).
  - rom_address = (DrawY-sy)*W + (DrawX-sx), zero-extended to ADDR_W. It is 0 when not inbox.
  - v1 <= pix_valid; in1 <= inbox.
  - rom_address holds its last value when pix_valid = 0.
- Stage 2 (next edge):
  - pix_out_valid <= v1.
  - ball_on <= v1 && in1 && rom_data != 0.
  - ball_color_idx <= ball_on-condition ? rom_data : 0.
- Latency is exactly 2 cycles. Throughput is 1 pixel/cycle, with no stalls and no backpressure.
- Bubbles: pix_valid low produces pix_out_valid low 2 cycles later. In that case ball_on and ball_color_idx are forced to 0.
- Counter:
  - cnt increments on each cycle with stage-2 ball_on asserted, saturating at 2^CNT_W-1.
  - On frame_start: last_frame_count <= cnt plus the ball_on pixel retiring that same cycle (saturating), then cnt <= 0.
  - The ball_on pixel retiring in the frame_start cycle counts toward the closing frame.
- Boundary cases:
  - Box partly off-screen (sx+W > 639 or > 1023): only on-screen coordinates can match, with no wrap.
  - sx = 0, DrawX = 0: the pixel is inbox.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, last_frame_count = 0.
- frame_start with ball_x=100, ball_y=50, size 0, fire 0; pixel (103,52) -> rom_address = 2*8+3 = 19 one cycle later. Pixel returns 2 cycles later with ball_color_idx = rom_data, ball_on = 1 when rom_data = 5.
- Same setup, rom_data = 0 at (100,50); pixels (108,50) and (99,50) -> all three give pix_out_valid = 1, ball_on = 0, color 0. (108,50) and (99,50) are outside the box and drive rom_address = 0.
- Fire with size 0, pixel (115,65) at ball (100,50) -> W = 16, rom_address = 15*16+15 = 255, rom_is_fire = 1.
- Full 16x16 scan with model ROM having 200 nonzero entries, then frame_start -> last_frame_count = 200. The last opaque pixel retires in the frame_start cycle and is included.
- ball_x changed mid-frame without frame_start -> addressing is unchanged. Pixel in the frame_start cycle uses the old box; the next pixel uses the new box.
- Reset asserted with 2 pixels in flight -> no pix_out_valid afterwards, counter 0.

Source files
------------

// File: rtl/ball_sprite_fetch.sv
// Two-stage ball sprite ROM reader: box test and address in stage 1, palette
// return in stage 2, with frame-latched ball state and a per-frame opaque pixel count.
module ball_sprite_fetch #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned CNT_W   = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [1:0]         ball_size_in,
    input  logic               is_fire_in,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [3:0]         rom_data,
    output logic [ADDR_W-1:0]  rom_address,
    output logic [1:0]         rom_ball_size,
    output logic               rom_is_fire,
    output logic               pix_out_valid,
    output logic               ball_on,
    output logic [3:0]         ball_color_idx,
    output logic [CNT_W-1:0]   last_frame_count
);

    // One extra bit so sx+W never wraps back onto low coordinates.
    localparam int unsigned XW = COORD_W + 1;

    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic [1:0]         ssize;
    logic               sfire;

    logic               v1;
    logic               in1;
    logic [CNT_W-1:0]   cnt;

    logic [XW-1:0]      w_c;
    logic [XW-1:0]      px_c;
    logic [XW-1:0]      py_c;
    logic [XW-1:0]      bx_c;
    logic [XW-1:0]      by_c;
    logic [XW-1:0]      dx_c;
    logic [XW-1:0]      dy_c;
    logic               inbox_c;
    logic [ADDR_W-1:0]  addr_c;
    logic               hit_c;
    logic [CNT_W-1:0]   cnt_sum_c;

    assign rom_ball_size = ssize;
    assign rom_is_fire   = sfire;

    // Stage-1 box test and sprite-relative address from the frame shadow.
    always_comb begin
        w_c = XW'(16);
        if (!sfire) begin
            case (ssize)
                2'd0:    w_c = XW'(8);
                2'd1:    w_c = XW'(12);
                default: w_c = XW'(16);
            endcase
        end
        px_c    = XW'(DrawX);
        py_c    = XW'(DrawY);
        bx_c    = XW'(sx);
        by_c    = XW'(sy);
        dx_c    = px_c - bx_c;
        dy_c    = py_c - by_c;
        inbox_c = (px_c >= bx_c) && (px_c < bx_c + w_c) &&
                  (py_c >= by_c) && (py_c < by_c + w_c);
        addr_c  = '0;
        if (inbox_c) begin
            addr_c = ADDR_W'(dy_c) * ADDR_W'(w_c) + ADDR_W'(dx_c);
        end
    end

    // Stage-2 opacity and the count including the pixel retiring this cycle.
    always_comb begin
        hit_c     = v1 && in1 && (rom_data != 4'd0);
        cnt_sum_c = cnt;
        if (ball_on && (cnt != {CNT_W{1'b1}})) begin
            cnt_sum_c = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx               <= '0;
            sy               <= '0;
            ssize            <= '0;
            sfire            <= 1'b0;
            v1               <= 1'b0;
            in1              <= 1'b0;
            rom_address      <= '0;
            pix_out_valid    <= 1'b0;
            ball_on          <= 1'b0;
            ball_color_idx   <= '0;
            cnt              <= '0;
            last_frame_count <= '0;
        end else begin
            if (frame_start) begin
                sx    <= ball_x;
                sy    <= ball_y;
                ssize <= ball_size_in;
                sfire <= is_fire_in;
            end
            v1  <= pix_valid;
            in1 <= pix_valid && inbox_c;
            if (pix_valid) begin
                rom_address <= addr_c;
            end
            pix_out_valid  <= v1;
            ball_on        <= hit_c;
            ball_color_idx <= hit_c ? rom_data : 4'd0;
            if (frame_start) begin
                last_frame_count <= cnt_sum_c;
                cnt              <= '0;
            end else begin
                cnt <= cnt_sum_c;
            end
        end
    end

endmodule

// File: tb/tb_ball_sprite_fetch.sv
// Bench for ball_sprite_fetch: vector table plus hand sequences, with a
// scoreboard queue checked whenever a pixel result leaves the pipeline.
module tb_ball_sprite_fetch;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned CNT_W   = 9;

    logic               Clk;
    logic               Reset;
    logic               frame_start;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [1:0]         ball_size_in;
    logic               is_fire_in;
    logic               pix_valid;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic [3:0]         rom_data;
    logic [ADDR_W-1:0]  rom_address;
    logic [1:0]         rom_ball_size;
    logic               rom_is_fire;
    logic               pix_out_valid;
    logic               ball_on;
    logic [3:0]         ball_color_idx;
    logic [CNT_W-1:0]   last_frame_count;

    logic [3:0] rom_mem [256];

    typedef struct {
        logic       on;
        logic [3:0] col;
    } exp_t;

    typedef struct {
        int bx; int by; int size; int fire;
        int x;  int y;  int rv;
        int eaddr; int eon; int ecol;
    } vec_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   model_cnt;

    ball_sprite_fetch #(.ADDR_W(ADDR_W), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .ball_x(ball_x), .ball_y(ball_y), .ball_size_in(ball_size_in),
        .is_fire_in(is_fire_in), .pix_valid(pix_valid), .DrawX(DrawX),
        .DrawY(DrawY), .rom_data(rom_data), .rom_address(rom_address),
        .rom_ball_size(rom_ball_size), .rom_is_fire(rom_is_fire),
        .pix_out_valid(pix_out_valid), .ball_on(ball_on),
        .ball_color_idx(ball_color_idx), .last_frame_count(last_frame_count)
    );

    assign rom_data = (rom_address < ADDR_W'(256)) ? rom_mem[rom_address[7:0]] : 4'd0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Result monitor: pops one expectation per valid result, bubbles must be blank.
    always @(negedge Clk) begin
        exp_t e;
        if (pix_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pix_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("ball_on", 32'(ball_on), 32'(e.on));
                chk("ball_color_idx", 32'(ball_color_idx), 32'(e.col));
                if (e.on && model_cnt < 511) model_cnt++;
            end
        end else begin
            chk("bubble_ball_on", 32'(ball_on), 32'd0);
            chk("bubble_color", 32'(ball_color_idx), 32'd0);
        end
    end

    task automatic step(input logic pv, input int x, input int y, input logic fs,
                        input int ea, input logic eo, input int ec);
        exp_t e;
        pix_valid   = pv;
        DrawX       = COORD_W'(x);
        DrawY       = COORD_W'(y);
        frame_start = fs;
        if (pv) begin
            e.on  = eo;
            e.col = 4'(ec);
            sb.push_back(e);
        end
        @(posedge Clk);
        #1;
        if (pv) chk("rom_address", 32'(rom_address), 32'(ea));
        if (fs) begin
            chk("last_frame_count", 32'(last_frame_count), 32'(model_cnt));
            model_cnt = 0;
            chk("rom_ball_size", 32'(rom_ball_size), 32'(ball_size_in));
            chk("rom_is_fire", 32'(rom_is_fire), 32'(is_fire_in));
        end
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic set_ball(input int bx, input int by, input int sz, input int fi);
        ball_x       = COORD_W'(bx);
        ball_y       = COORD_W'(by);
        ball_size_in = 2'(sz);
        is_fire_in   = 1'(fi);
    endtask

    initial begin
        vec_t vt[11];
        int   a;
        n_cmp = 0; n_bad = 0; model_cnt = 0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 4'd0;
        Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        DrawX = '0; DrawY = '0;
        set_ball(0, 0, 0, 0);

        //        bx   by  sz fi   x    y   rv  addr on col
        vt[0]  = '{100,  50, 0, 0, 103,  52, 5,  19, 1, 5};
        vt[1]  = '{100,  50, 0, 0, 100,  50, 0,   0, 0, 0};
        vt[2]  = '{100,  50, 0, 0, 108,  50, 0,   0, 0, 0};
        vt[3]  = '{100,  50, 0, 0,  99,  50, 0,   0, 0, 0};
        vt[4]  = '{100,  50, 0, 1, 115,  65, 9, 255, 1, 9};
        vt[5]  = '{  0,   0, 1, 0,  11,  11, 7, 143, 1, 7};
        vt[6]  = '{  0,   0, 1, 0,  12,   0, 6,   0, 0, 0};
        vt[7]  = '{  0,   0, 0, 0,   0,   0, 2,   0, 1, 2};
        vt[8]  = '{1020,  0, 2, 0,   3,   0, 4,   0, 0, 0};
        vt[9]  = '{1020,  0, 3, 0, 1023,  1, 8,  19, 1, 8};
        vt[10] = '{630, 470, 2, 0, 639, 479, 1, 153, 1, 1};

        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        idle(10);
        chk("rst_pix_out_valid", 32'(pix_out_valid), 32'd0);
        chk("rst_ball_on", 32'(ball_on), 32'd0);
        chk("rst_color", 32'(ball_color_idx), 32'd0);
        chk("rst_rom_address", 32'(rom_address), 32'd0);
        chk("rst_rom_ball_size", 32'(rom_ball_size), 32'd0);
        chk("rst_rom_is_fire", 32'(rom_is_fire), 32'd0);
        chk("rst_last_frame_count", 32'(last_frame_count), 32'd0);

        for (int i = 0; i < 11; i++) begin
            set_ball(vt[i].bx, vt[i].by, vt[i].size, vt[i].fire);
            step(1'b0, 0, 0, 1'b1, 0, 1'b0, 0);
            rom_mem[vt[i].eaddr] = 4'(vt[i].rv);
            step(1'b1, vt[i].x, vt[i].y, 1'b0, vt[i].eaddr, 1'(vt[i].eon), vt[i].ecol);
        end

        // Full 16x16 scan: 200 opaque entries, the last one retiring with frame_start.
        idle(3);
        set_ball(100, 50, 2, 0);
        step(1'b0, 0, 0, 1'b1, 0, 1'b0, 0);
        for (int i = 0; i < 256; i++) rom_mem[i] = (i >= 56) ? 4'(i % 15 + 1) : 4'd0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                a = r * 16 + c;
                step(1'b1, 100 + c, 50 + r, 1'b0, a, rom_mem[a] != 4'd0, int'(rom_mem[a]));
            end
        end
        idle(1);
        chk("rom_address_hold", 32'(rom_address), 32'd255);
        step(1'b0, 0, 0, 1'b1, 0, 1'b0, 0);
        chk("scan_count", 32'(last_frame_count), 32'd200);

        // Live ball_x change only takes effect through frame_start.
        idle(3);
        set_ball(100, 50, 0, 0);
        step(1'b0, 0, 0, 1'b1, 0, 1'b0, 0);
        rom_mem[19] = 4'd3; rom_mem[20] = 4'd6; rom_mem[0] = 4'd0;
        ball_x = COORD_W'(200);
        step(1'b1, 103, 52, 1'b0, 19, 1'b1, 3);
        step(1'b1, 104, 52, 1'b1, 20, 1'b1, 6);
        step(1'b1, 204, 52, 1'b0, 20, 1'b1, 6);
        step(1'b1, 104, 52, 1'b0, 0, 1'b0, 0);

        // Reset with one pixel in stage 1 and another on the inputs.
        idle(3);
        step(1'b1, 203, 52, 1'b0, 19, 1'b1, 3);
        sb.delete();
        Reset = 1'b1; pix_valid = 1'b1; DrawX = COORD_W'(204); DrawY = COORD_W'(52);
        @(posedge Clk);
        #1;
        Reset = 1'b0; pix_valid = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            chk("flush_pix_out_valid", 32'(pix_out_valid), 32'd0);
        end
        chk("flush_last_frame_count", 32'(last_frame_count), 32'd0);
        chk("flush_rom_address", 32'(rom_address), 32'd0);
        chk("flush_rom_ball_size", 32'(rom_ball_size), 32'd0);
        step(1'b0, 0, 0, 1'b1, 0, 1'b0, 0);

        idle(3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
